// File: rtl/robotron_arb_pkg.sv
// rtl/robotron_arb_pkg.sv - shared states, defaults and counter width for the robotron halt arbiter
package robotron_arb_pkg;

    localparam int               CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam int ACK_TIMEOUT_DEF = 16;
    localparam int REARM_GAP_DEF   = 2;
    localparam int MAX_BURST_DEF   = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT_REQ,
        ST_WAIT_ACK,
        ST_GRANTED,
        ST_RELEASE,
        ST_GAP
    } arb_state_t;

endpackage

// File: rtl/robotron_ecycle_counter.sv
// rtl/robotron_ecycle_counter.sv - saturating E-cycle counter with clear, load and terminal-count flag
module robotron_ecycle_counter
    import robotron_arb_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             e_fall,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             inc_en,
    input  logic [CNT_W-1:0] terminal,
    output logic             tc_next
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             at_max;

    assign at_max    = (count == CNT_MAX);
    assign count_inc = count + CNT_W'(1);

    // Flags that an advance on this e_fall lands exactly on the terminal count,
    // so the owner can act on the same CLK without waiting for the register.
    assign tc_next = e_fall && !at_max && (count_inc == terminal);

    // Count register: clear beats load beats advance; holds at all-ones.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (e_fall && inc_en && !at_max) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/robotron_halt_arbiter.sv
// rtl/robotron_halt_arbiter.sv - 6809 HALT_N/BA/BS bus hand-off between CPU and blitter; ARB_BURST_LIMIT_EN adds a burst limit
module robotron_halt_arbiter
    import robotron_arb_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int REARM_GAP   = REARM_GAP_DEF
`ifdef ARB_BURST_LIMIT_EN
    ,
    parameter int MAX_BURST   = MAX_BURST_DEF
`endif
)(
    input  logic CLK,
    input  logic RESET_N,
    input  logic e_fall,
    input  logic blt_req,
    input  logic blt_done,
    input  logic BA,
    input  logic BS,
    output logic HALT_N,
    output logic blt_grant,
    output logic ack_timeout,
    output logic preempt
);

    localparam logic [CNT_W-1:0] ACK_TERM = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] GAP_TERM = CNT_W'(REARM_GAP);

    arb_state_t state_q, state_d;
    logic       halt_n_q, halt_n_d;
    logic       grant_q, grant_d;
    logic       ack_to_q, ack_to_d;
    logic       ack_clr, ack_inc, ack_tc_next;
    logic       gap_clr, gap_inc, gap_tc_next;
    logic       cpu_halted;

    // BA and BS are sampled as they stand on the e_fall CLK itself.
    assign cpu_halted = BA && BS;

    robotron_ecycle_counter u_ack_cnt (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .e_fall     (e_fall),
        .clear      (ack_clr),
        .load       (1'b0),
        .load_value ('0),
        .inc_en     (ack_inc),
        .terminal   (ACK_TERM),
        .tc_next    (ack_tc_next)
    );

    robotron_ecycle_counter u_gap_cnt (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .e_fall     (e_fall),
        .clear      (gap_clr),
        .load       (1'b0),
        .load_value ('0),
        .inc_en     (gap_inc),
        .terminal   (GAP_TERM),
        .tc_next    (gap_tc_next)
    );

`ifdef ARB_BURST_LIMIT_EN
    localparam logic [CNT_W-1:0] BURST_TERM = CNT_W'(MAX_BURST);

    logic preempt_q, preempt_d;
    logic burst_clr, burst_inc, burst_tc_next;

    robotron_ecycle_counter u_burst_cnt (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .e_fall     (e_fall),
        .clear      (burst_clr),
        .load       (1'b0),
        .load_value ('0),
        .inc_en     (burst_inc),
        .terminal   (BURST_TERM),
        .tc_next    (burst_tc_next)
    );

    assign preempt = preempt_q;
`else
    assign preempt = 1'b0;
`endif

    // State and output registers; reset drops the grant at once and parks HALT_N high.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            halt_n_q  <= 1'b1;
            grant_q   <= 1'b0;
            ack_to_q  <= 1'b0;
`ifdef ARB_BURST_LIMIT_EN
            preempt_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            halt_n_q  <= halt_n_d;
            grant_q   <= grant_d;
            ack_to_q  <= ack_to_d;
`ifdef ARB_BURST_LIMIT_EN
            preempt_q <= preempt_d;
`endif
        end
    end

    // Next-state logic; HALT_N only ever changes inside an e_fall branch.
    always_comb begin
        state_d  = state_q;
        halt_n_d = halt_n_q;
        grant_d  = grant_q;
        ack_to_d = 1'b0;
        ack_clr  = 1'b0;
        ack_inc  = 1'b0;
        gap_clr  = 1'b0;
        gap_inc  = 1'b0;
`ifdef ARB_BURST_LIMIT_EN
        preempt_d = 1'b0;
        burst_clr = 1'b0;
        burst_inc = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                grant_d = 1'b0;
                if (blt_req) begin
                    state_d = ST_HALT_REQ;
                end
            end
            ST_HALT_REQ: begin
                if (!blt_req) begin
                    state_d = ST_IDLE;
                end else if (e_fall) begin
                    halt_n_d = 1'b0;
                    ack_clr  = 1'b1;
                    state_d  = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (!blt_req) begin
                    state_d = ST_RELEASE;
                end else if (e_fall) begin
                    if (cpu_halted) begin
                        grant_d = 1'b1;
                        state_d = ST_GRANTED;
`ifdef ARB_BURST_LIMIT_EN
                        burst_clr = 1'b1;
`endif
                    end else begin
                        ack_inc = 1'b1;
                        if (ack_tc_next) begin
                            ack_to_d = 1'b1;
                            state_d  = ST_RELEASE;
                        end
                    end
                end
            end
            ST_GRANTED: begin
                grant_d = 1'b1;
                if (blt_done || !blt_req) begin
                    grant_d = 1'b0;
                    state_d = ST_RELEASE;
                end
`ifdef ARB_BURST_LIMIT_EN
                else if (e_fall) begin
                    burst_inc = 1'b1;
                    if (burst_tc_next) begin
                        preempt_d = 1'b1;
                        grant_d   = 1'b0;
                        state_d   = ST_RELEASE;
                    end
                end
`endif
            end
            ST_RELEASE: begin
                grant_d = 1'b0;
                if (e_fall) begin
                    if (!halt_n_q) begin
                        halt_n_d = 1'b1;
                    end else if (!BA) begin
                        gap_clr = 1'b1;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                grant_d = 1'b0;
                if (e_fall) begin
                    gap_inc = 1'b1;
                    if (gap_tc_next) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                halt_n_d = 1'b1;
                grant_d  = 1'b0;
            end
        endcase
    end

    assign HALT_N      = halt_n_q;
    assign blt_grant   = grant_q;
    assign ack_timeout = ack_to_q;

endmodule

// File: tb/tb_robotron_halt_arbiter.sv
// tb/tb_robotron_halt_arbiter.sv - directed self-checking bench for robotron_halt_arbiter
module tb_robotron_halt_arbiter;

    logic CLK = 1'b0;
    logic RESET_N;
    logic e_fall = 1'b0;
    logic blt_req;
    logic blt_done;
    logic BA = 1'b0;
    logic BS = 1'b0;
    logic HALT_N;
    logic blt_grant;
    logic ack_timeout;
    logic preempt;

    logic       cpu_en;
    logic [1:0] ediv = 2'd0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         grant_seen = 0;
    int         ack_seen = 0;
    int         preempt_seen = 0;
    int         inv_viol = 0;

    robotron_halt_arbiter #(
        .ACK_TIMEOUT (4),
        .REARM_GAP   (2)
`ifdef ARB_BURST_LIMIT_EN
        ,
        .MAX_BURST   (8)
`endif
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .e_fall      (e_fall),
        .blt_req     (blt_req),
        .blt_done    (blt_done),
        .BA          (BA),
        .BS          (BS),
        .HALT_N      (HALT_N),
        .blt_grant   (blt_grant),
        .ack_timeout (ack_timeout),
        .preempt     (preempt)
    );

    always #5 CLK = ~CLK;

    // E period is four CLKs; e_fall is high for one CLK of each.
    always @(negedge CLK) begin
        ediv   = ediv + 2'd1;
        e_fall = (ediv == 2'd3);
    end

    // CPU model: one E cycle after it sees HALT_N low it reports BA=BS=1.
    always @(posedge CLK) begin
        if (e_fall) begin
            #1;
            BA = cpu_en & ~HALT_N;
            BS = cpu_en & ~HALT_N;
        end
    end

    // Running tallies of output activity and of grant-without-halt.
    always @(negedge CLK) begin
        if (blt_grant === 1'b1) grant_seen++;
        if (ack_timeout === 1'b1) ack_seen++;
        if (preempt === 1'b1) preempt_seen++;
        if (blt_grant === 1'b1 && HALT_N !== 1'b0) inv_viol++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_efall();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(posedge CLK);
            if (e_fall) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL wait_efall: no e_fall within 16 CLK, required one");
        end
        @(negedge CLK);
    endtask

    task automatic drain();
        blt_req = 1'b0;
        for (int i = 0; i < 5; i++) wait_efall();
        n_checks++;
        if (HALT_N !== 1'b1) begin n_fail++; $display("FAIL drain_halt: HALT_N=%b required 1", HALT_N); end
        n_checks++;
        if (blt_grant !== 1'b0) begin n_fail++; $display("FAIL drain_grant: blt_grant=%b required 0", blt_grant); end
    endtask

    task automatic test_reset();
        RESET_N  = 1'b0;
        blt_req  = 1'b0;
        blt_done = 1'b0;
        cpu_en   = 1'b1;
        repeat (6) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (HALT_N !== 1'b1) begin n_fail++; $display("FAIL reset_halt: HALT_N=%b required 1", HALT_N); end
        n_checks++;
        if (blt_grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant: blt_grant=%b required 0", blt_grant); end
        n_checks++;
        if (ack_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_ack: ack_timeout=%b required 0", ack_timeout); end
        n_checks++;
        if (preempt !== 1'b0) begin n_fail++; $display("FAIL reset_preempt: preempt=%b required 0", preempt); end
    endtask

    task automatic test_basic_grant();
        cpu_en = 1'b1;
        wait_efall();
        blt_req = 1'b1;
        wait_efall();
        n_checks++;
        if (HALT_N !== 1'b0) begin n_fail++; $display("FAIL basic_halt_low: HALT_N=%b required 0", HALT_N); end
        n_checks++;
        if (blt_grant !== 1'b0) begin n_fail++; $display("FAIL basic_no_early_grant: blt_grant=%b required 0", blt_grant); end
        wait_efall();
        n_checks++;
        if (blt_grant !== 1'b1) begin n_fail++; $display("FAIL basic_grant: blt_grant=%b required 1", blt_grant); end
        blt_done = 1'b1;
        @(negedge CLK);
        blt_done = 1'b0;
        blt_req  = 1'b0;
        n_checks++;
        if (blt_grant !== 1'b0) begin n_fail++; $display("FAIL basic_grant_drop: blt_grant=%b required 0", blt_grant); end
        n_checks++;
        if (HALT_N !== 1'b0) begin n_fail++; $display("FAIL basic_halt_held: HALT_N=%b required 0", HALT_N); end
        wait_efall();
        n_checks++;
        if (HALT_N !== 1'b1) begin n_fail++; $display("FAIL basic_halt_release: HALT_N=%b required 1", HALT_N); end
        drain();
    endtask

    task automatic test_timeout();
        int g0, a0;
        cpu_en = 1'b0;
        wait_efall();
        g0 = grant_seen;
        a0 = ack_seen;
        blt_req = 1'b1;
        wait_efall();
        for (int i = 1; i <= 3; i++) begin
            wait_efall();
            n_checks++;
            if (ack_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early e_fall %0d: ack_timeout=%b required 0", i, ack_timeout); end
        end
        wait_efall();
        n_checks++;
        if (ack_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse: ack_timeout=%b required 1", ack_timeout); end
        n_checks++;
        if (HALT_N !== 1'b0) begin n_fail++; $display("FAIL timeout_halt_held: HALT_N=%b required 0", HALT_N); end
        blt_req = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (ack_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_one_clk: ack_timeout=%b required 0", ack_timeout); end
        wait_efall();
        n_checks++;
        if (HALT_N !== 1'b1) begin n_fail++; $display("FAIL timeout_release: HALT_N=%b required 1", HALT_N); end
        drain();
        n_checks++;
        if (ack_seen - a0 !== 1) begin n_fail++; $display("FAIL timeout_count: pulses=%0d required 1", ack_seen - a0); end
        n_checks++;
        if (grant_seen - g0 !== 0) begin n_fail++; $display("FAIL timeout_no_grant: grant CLKs=%0d required 0", grant_seen - g0); end
    endtask

    task automatic test_withdraw();
        int g0;
        cpu_en = 1'b0;
        wait_efall();
        g0 = grant_seen;
        blt_req = 1'b1;
        wait_efall();
        blt_req = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (HALT_N !== 1'b0) begin n_fail++; $display("FAIL withdraw_halt_held: HALT_N=%b required 0", HALT_N); end
        wait_efall();
        n_checks++;
        if (HALT_N !== 1'b1) begin n_fail++; $display("FAIL withdraw_release: HALT_N=%b required 1", HALT_N); end
        blt_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_efall();
            n_checks++;
            if (HALT_N !== 1'b1) begin n_fail++; $display("FAIL withdraw_gap e_fall %0d: HALT_N=%b required 1", i, HALT_N); end
        end
        wait_efall();
        n_checks++;
        if (HALT_N !== 1'b0) begin n_fail++; $display("FAIL withdraw_rehalt: HALT_N=%b required 0", HALT_N); end
        n_checks++;
        if (grant_seen - g0 !== 0) begin n_fail++; $display("FAIL withdraw_no_grant: grant CLKs=%0d required 0", grant_seen - g0); end
        drain();
    endtask

    task automatic test_async_reset();
        cpu_en = 1'b1;
        wait_efall();
        blt_req = 1'b1;
        wait_efall();
        wait_efall();
        n_checks++;
        if (blt_grant !== 1'b1) begin n_fail++; $display("FAIL areset_pre_grant: blt_grant=%b required 1", blt_grant); end
        @(negedge CLK);
        #1 RESET_N = 1'b0;
        #1;
        n_checks++;
        if (blt_grant !== 1'b0) begin n_fail++; $display("FAIL areset_grant: blt_grant=%b required 0", blt_grant); end
        n_checks++;
        if (HALT_N !== 1'b1) begin n_fail++; $display("FAIL areset_halt: HALT_N=%b required 1", HALT_N); end
        wait_efall();
        RESET_N = 1'b1;
        wait_efall();
        n_checks++;
        if (HALT_N !== 1'b0) begin n_fail++; $display("FAIL areset_restart_halt: HALT_N=%b required 0", HALT_N); end
        n_checks++;
        if (blt_grant !== 1'b0) begin n_fail++; $display("FAIL areset_restart_early: blt_grant=%b required 0", blt_grant); end
        wait_efall();
        n_checks++;
        if (blt_grant !== 1'b1) begin n_fail++; $display("FAIL areset_restart_grant: blt_grant=%b required 1", blt_grant); end
        drain();
    endtask

    task automatic test_back_to_back();
        cpu_en = 1'b1;
        wait_efall();
        blt_req = 1'b1;
        wait_efall();
        wait_efall();
        repeat (3) @(negedge CLK);
        blt_done = 1'b1;
        wait_efall();
        blt_done = 1'b0;
        n_checks++;
        if (blt_grant !== 1'b0) begin n_fail++; $display("FAIL b2b_grant_drop: blt_grant=%b required 0", blt_grant); end
        n_checks++;
        if (HALT_N !== 1'b0) begin n_fail++; $display("FAIL b2b_same_efall: HALT_N=%b required 0", HALT_N); end
        for (int i = 0; i < 4; i++) begin
            wait_efall();
            n_checks++;
            if (HALT_N !== 1'b1) begin n_fail++; $display("FAIL b2b_gap e_fall %0d: HALT_N=%b required 1", i, HALT_N); end
        end
        wait_efall();
        n_checks++;
        if (HALT_N !== 1'b0) begin n_fail++; $display("FAIL b2b_rehalt: HALT_N=%b required 0", HALT_N); end
        wait_efall();
        n_checks++;
        if (blt_grant !== 1'b1) begin n_fail++; $display("FAIL b2b_regrant: blt_grant=%b required 1", blt_grant); end
        drain();
    endtask

`ifdef ARB_BURST_LIMIT_EN
    task automatic test_burst_limit();
        cpu_en = 1'b1;
        wait_efall();
        blt_req = 1'b1;
        wait_efall();
        wait_efall();
        for (int i = 1; i <= 7; i++) begin
            wait_efall();
            n_checks++;
            if (blt_grant !== 1'b1 || preempt !== 1'b0) begin
                n_fail++; $display("FAIL burst_hold e_fall %0d: grant=%b preempt=%b required 1 0", i, blt_grant, preempt);
            end
        end
        wait_efall();
        n_checks++;
        if (preempt !== 1'b1) begin n_fail++; $display("FAIL burst_preempt: preempt=%b required 1", preempt); end
        n_checks++;
        if (blt_grant !== 1'b0) begin n_fail++; $display("FAIL burst_grant_drop: blt_grant=%b required 0", blt_grant); end
        @(negedge CLK);
        n_checks++;
        if (preempt !== 1'b0) begin n_fail++; $display("FAIL burst_one_clk: preempt=%b required 0", preempt); end
        for (int i = 0; i < 4; i++) begin
            wait_efall();
            n_checks++;
            if (HALT_N !== 1'b1) begin n_fail++; $display("FAIL burst_gap e_fall %0d: HALT_N=%b required 1", i, HALT_N); end
        end
        wait_efall();
        n_checks++;
        if (HALT_N !== 1'b0) begin n_fail++; $display("FAIL burst_rearm_halt: HALT_N=%b required 0", HALT_N); end
        wait_efall();
        n_checks++;
        if (blt_grant !== 1'b1) begin n_fail++; $display("FAIL burst_rearm_grant: blt_grant=%b required 1", blt_grant); end
        drain();
    endtask
`else
    task automatic test_no_preempt();
        n_checks++;
        if (preempt_seen !== 0) begin n_fail++; $display("FAIL no_preempt: preempt CLKs=%0d required 0", preempt_seen); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_grant();
        test_timeout();
        test_withdraw();
        test_async_reset();
        test_back_to_back();
`ifdef ARB_BURST_LIMIT_EN
        test_burst_limit();
`else
        test_no_preempt();
`endif
        n_checks++;
        if (inv_viol !== 0) begin n_fail++; $display("FAIL grant_implies_halt: violations=%0d required 0", inv_viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
